// File: rtl/mmio_fifo_pkg.sv
// Shared constants and types for the MMIO FIFO bank: DFH value, register offsets,
// status bit positions and the per-channel status record.
package mmio_fifo_pkg;

  // Feature type AFU (4'h1) in [63:60], end-of-list in bit 40.
  localparam logic [63:0] DFH_VALUE = 64'h1000_0100_0000_0000;

  localparam logic [15:0] CSR_DFH      = 16'h0000;
  localparam logic [15:0] CSR_AFU_ID_L = 16'h0002;
  localparam logic [15:0] CSR_AFU_ID_H = 16'h0004;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_PEEK   = 3'd4;
  localparam int         CH_STRIDE  = 8;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;
  localparam int STAT_UDF_BIT   = 19;

  typedef struct packed {
    logic [15:0] count;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        udf;
  } t_fifo_status;

  function automatic logic [63:0] pack_status(t_fifo_status s);
    logic [63:0] v;
    v                 = '0;
    v[15:0]           = s.count;
    v[STAT_EMPTY_BIT] = s.empty;
    v[STAT_FULL_BIT]  = s.full;
    v[STAT_OVF_BIT]   = s.ovf;
    v[STAT_UDF_BIT]   = s.udf;
    return v;
  endfunction

endpackage

// File: rtl/mmio_fifo_bank_if.sv
// Host MMIO request/response bundle between the AFU decode (master) and the
// FIFO bank responder (slave).
interface mmio_fifo_bank_if;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wr_data;
  logic        rd_rsp_valid;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
    input  rd_rsp_valid, rd_rsp_tid, rd_rsp_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
    output rd_rsp_valid, rd_rsp_tid, rd_rsp_data
  );
endinterface

// File: rtl/mmio_fifo_chan.sv
// One circular-buffer FIFO channel with sticky overflow/underflow flags.
// Flush beats push/pop; a full channel may accept a push when a pop succeeds.
module mmio_fifo_chan
  import mmio_fifo_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic              i_clr_sticky,
  output logic [DATA_W-1:0] o_head,
  output t_fifo_status      o_status,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_full;
  logic              r_empty;
  logic              r_ovf;
  logic              r_udf;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_pop_ok  = i_pop && !r_empty;
  assign w_push_ok = i_push && (!r_full || w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Set beats clear if both land in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !i_clr_sticky) || (i_push && !w_push_ok);
      r_udf <= (r_udf && !i_clr_sticky) || (i_pop && r_empty);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush && !rst) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_head         = r_mem[r_rd_ptr];
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_status.count = 16'(r_count);
  assign o_status.empty = r_empty;
  assign o_status.full  = r_full;
  assign o_status.ovf   = r_ovf;
  assign o_status.udf   = r_udf;

endmodule

// File: rtl/mmio_fifo_bank.sv
// Bank of NUM_CH host-visible FIFOs plus DFH/AFU-ID CSRs; full MMIO responder.
// Optional build macro MMIO_FIFO_PEEK_EN enables the non-destructive PEEK read.
module mmio_fifo_bank
  import mmio_fifo_pkg::*;
#(
  parameter int           NUM_CH    = 2,
  parameter int           DATA_W    = 64,
  parameter int           DEPTH     = 16,
  parameter logic [15:0]  BASE_ADDR = 16'h0020,
  parameter logic [127:0] AFU_ID    = 128'h0
) (
  input  logic              clk,
  input  logic              rst,
  mmio_fifo_bank_if.slave   mmio,
  output logic [NUM_CH-1:0] ch_full,
  output logic [NUM_CH-1:0] ch_empty
);

  localparam int CH_SPAN = NUM_CH * CH_STRIDE;

  logic [16:0]       w_off;
  logic              w_in_bank;
  logic [12:0]       w_ch_sel;
  logic [2:0]        w_reg;
  logic [NUM_CH-1:0] w_ch_hit;
  logic [DATA_W-1:0] w_head   [NUM_CH];
  t_fifo_status      w_status [NUM_CH];
  logic [63:0]       w_rd_data;
  logic              w_unused;

  logic              r_rsp_valid;
  logic [8:0]        r_rsp_tid;
  logic [63:0]       r_rsp_data;

  // 17-bit difference so addresses below BASE_ADDR cannot alias into the bank.
  assign w_off     = {1'b0, mmio.mmio_addr} - {1'b0, BASE_ADDR};
  assign w_in_bank = (mmio.mmio_addr >= BASE_ADDR) && (w_off < 17'(CH_SPAN));
  assign w_ch_sel  = w_off[15:3];
  assign w_reg     = w_off[2:0];
  assign w_unused  = ^{w_off[16], mmio.mmio_wr_data};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_ch_hit[c] = w_in_bank && (w_ch_sel == 13'(c));

    mmio_fifo_chan #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .i_push       (mmio.mmio_wr_valid && w_ch_hit[c] && (w_reg == REG_DATA)),
      .i_push_data  (mmio.mmio_wr_data[DATA_W-1:0]),
      .i_pop        (mmio.mmio_rd_valid && w_ch_hit[c] && (w_reg == REG_DATA)),
      .i_flush      (mmio.mmio_wr_valid && w_ch_hit[c] && (w_reg == REG_STATUS)
                     && mmio.mmio_wr_data[0]),
      .i_clr_sticky (mmio.mmio_wr_valid && w_ch_hit[c] && (w_reg == REG_STATUS)
                     && mmio.mmio_wr_data[1]),
      .o_head       (w_head[c]),
      .o_status     (w_status[c]),
      .o_full       (ch_full[c]),
      .o_empty      (ch_empty[c])
    );
  end

  always_comb begin
    w_rd_data = '0;
    if (w_in_bank) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ch_hit[c]) begin
          case (w_reg)
            REG_DATA:   w_rd_data = w_status[c].empty ? 64'd0 : 64'(w_head[c]);
            REG_STATUS: w_rd_data = pack_status(w_status[c]);
`ifdef MMIO_FIFO_PEEK_EN
            REG_PEEK:   w_rd_data = w_status[c].empty ? 64'd0 : 64'(w_head[c]);
`else
            REG_PEEK:   w_rd_data = '0;
`endif
            default:    w_rd_data = '0;
          endcase
        end
      end
    end else begin
      case (mmio.mmio_addr)
        CSR_DFH:      w_rd_data = DFH_VALUE;
        CSR_AFU_ID_L: w_rd_data = AFU_ID[63:0];
        CSR_AFU_ID_H: w_rd_data = AFU_ID[127:64];
        default:      w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= mmio.mmio_rd_valid;
      if (mmio.mmio_rd_valid) begin
        r_rsp_tid  <= mmio.mmio_tid;
        r_rsp_data <= w_rd_data;
      end
    end
  end

  assign mmio.rd_rsp_valid = r_rsp_valid;
  assign mmio.rd_rsp_tid   = r_rsp_tid;
  assign mmio.rd_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Self-checking bench for mmio_fifo_bank: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_mmio_fifo_bank;

  localparam int           NUM_CH = 2;
  localparam int           DEPTH  = 16;
  localparam logic [15:0]  BASE   = 16'h0020;
  localparam logic [127:0] AFU    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [63:0]  EXP_DFH = 64'h1000_0100_0000_0000;
`ifdef MMIO_FIFO_PEEK_EN
  localparam bit PEEK_EN = 1'b1;
`else
  localparam bit PEEK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] ch_empty;

  mmio_fifo_bank_if bus ();

  mmio_fifo_bank #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (64),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .AFU_ID    (AFU)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mmio     (bus.slave),
    .ch_full  (ch_full),
    .ch_empty (ch_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per channel plus sticky flags.
  logic [63:0] mq [NUM_CH][$];
  bit          movf [NUM_CH];
  bit          mudf [NUM_CH];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] addr;
    logic [8:0]  tid;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      movf[c] = 1'b0;
      mudf[c] = 1'b0;
    end
  endfunction

  // Returns the read value from pre-cycle state, then applies the cycle's effects.
  function automatic logic [63:0] model_step(bit wr, bit rd, logic [15:0] addr,
                                             logic [63:0] wd);
    logic [63:0] res;
    int          off;
    int          c;
    int          r;
    int          n;
    bit          popped;
    res    = '0;
    popped = 1'b0;
    if (addr == 16'h0000) res = EXP_DFH;
    else if (addr == 16'h0002) res = AFU[63:0];
    else if (addr == 16'h0004) res = AFU[127:64];
    else if (addr >= BASE && int'(addr) < int'(BASE) + 8 * NUM_CH) begin
      off = int'(addr) - int'(BASE);
      c   = off / 8;
      r   = off % 8;
      n   = mq[c].size();
      if (r == 0) res = (n > 0) ? mq[c][0] : 64'd0;
      if (r == 2) begin
        res     = 64'(n);
        res[16] = (n == 0);
        res[17] = (n == DEPTH);
        res[18] = movf[c];
        res[19] = mudf[c];
      end
      if (r == 4) res = (PEEK_EN && n > 0) ? mq[c][0] : 64'd0;
      if (rd && r == 0) begin
        if (n > 0) begin
          void'(mq[c].pop_front());
          popped = 1'b1;
        end else begin
          mudf[c] = 1'b1;
        end
      end
      if (wr && r == 0) begin
        if (n < DEPTH || popped) mq[c].push_back(wd);
        else movf[c] = 1'b1;
      end
      if (wr && r == 2) begin
        if (wd[0]) mq[c].delete();
        if (wd[1]) begin
          movf[c] = 1'b0;
          mudf[c] = 1'b0;
        end
      end
    end
    if (!rd) res = '0;
    return res;
  endfunction

  task automatic cycle_chk(bit wr, bit rd, logic [15:0] addr, logic [8:0] tid,
                           logic [63:0] wd, logic [63:0] exp, string name);
    logic [NUM_CH-1:0] ef;
    logic [NUM_CH-1:0] ee;
    bus.mmio_wr_valid = wr;
    bus.mmio_rd_valid = rd;
    bus.mmio_addr     = addr;
    bus.mmio_tid      = tid;
    bus.mmio_wr_data  = wd;
    @(posedge clk);
    #1;
    chk({name, ".valid"}, 64'(bus.rd_rsp_valid), 64'(rd));
    if (rd) begin
      chk({name, ".tid"}, 64'(bus.rd_rsp_tid), 64'(tid));
      chk({name, ".data"}, bus.rd_rsp_data, exp);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      ef[c] = (mq[c].size() == DEPTH);
      ee[c] = (mq[c].size() == 0);
    end
    chk({name, ".full"}, 64'(ch_full), 64'(ef));
    chk({name, ".empty"}, 64'(ch_empty), 64'(ee));
  endtask

  // Expectation from the model.
  task automatic op(bit wr, bit rd, logic [15:0] addr, logic [63:0] wd, string name);
    logic [63:0] e;
    e = model_step(wr, rd, addr, wd);
    cycle_chk(wr, rd, addr, 9'($urandom_range(0, 511)), wd, e, name);
  endtask

  // Expectation given explicitly; model still tracks state.
  task automatic op_x(bit wr, bit rd, logic [15:0] addr, logic [63:0] wd,
                      logic [63:0] exp, string name);
    void'(model_step(wr, rd, addr, wd));
    cycle_chk(wr, rd, addr, 9'($urandom_range(0, 511)), wd, exp, name);
  endtask

  task automatic idle();
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_rd_valid = 1'b0;
  endtask

  function automatic void add_vec(bit wr, bit rd, logic [15:0] a, logic [8:0] t,
                                  logic [63:0] wd, logic [63:0] e);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.tid = t; v.wdata = wd; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [15:0] a;
    logic [63:0] wd;
    bit          wr;
    bit          rd;
    int          sel;
    int          wp;
    int          rp;

    add_vec(0, 1, 16'h0000, 9'h005, 64'd0, EXP_DFH);
    add_vec(0, 1, 16'h0002, 9'h006, 64'd0, AFU[63:0]);
    add_vec(0, 1, 16'h0004, 9'h1FF, 64'd0, AFU[127:64]);
    add_vec(0, 1, 16'h0006, 9'h011, 64'd0, 64'd0);
    add_vec(0, 1, 16'h0008, 9'h012, 64'd0, 64'd0);
    add_vec(0, 1, 16'h0001, 9'h013, 64'd0, 64'd0);
    add_vec(0, 1, 16'h0030, 9'h014, 64'd0, 64'd0);
    add_vec(1, 0, 16'h0030, 9'h000, 64'd1, 64'd0);
    add_vec(0, 1, 16'h0022, 9'h015, 64'd0, 64'h1_0000);
    add_vec(0, 1, 16'h002A, 9'h016, 64'd0, 64'h1_0000);
    add_vec(0, 1, 16'h0026, 9'h017, 64'd0, 64'd0);
    add_vec(1, 0, 16'h0020, 9'h000, 64'h77, 64'd0);
    add_vec(0, 1, 16'h0022, 9'h018, 64'd0, 64'h1);
    add_vec(0, 1, 16'h0020, 9'h019, 64'd0, 64'h77);
    add_vec(0, 1, 16'h0022, 9'h01A, 64'd0, 64'h1_0000);

    rst = 1'b1;
    bus.mmio_addr    = '0;
    bus.mmio_tid     = '0;
    bus.mmio_wr_data = '0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 64'(bus.rd_rsp_valid), 64'd0);
    chk("rst.tid", 64'(bus.rd_rsp_tid), 64'd0);
    chk("rst.data", bus.rd_rsp_data, 64'd0);
    chk("rst.empty", 64'(ch_empty), 64'b11);
    chk("rst.full", 64'(ch_full), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      void'(model_step(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata));
      cycle_chk(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].tid, tbl[i].wdata,
                tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Fill ch0, overflow, drain in order.
    for (int i = 1; i <= 16; i++) op_x(1, 0, 16'h0020, 64'(i), 64'd0, "fill");
    op_x(0, 1, 16'h0022, 64'd0, 64'h2_0010, "full_status");
    op_x(1, 0, 16'h0020, 64'h11, 64'd0, "push_full");
    op_x(0, 1, 16'h0022, 64'd0, 64'h6_0010, "ovf_status");
    for (int i = 1; i <= 16; i++) op_x(0, 1, 16'h0020, 64'd0, 64'(i), "drain");
    op_x(0, 1, 16'h0022, 64'd0, 64'h5_0000, "drained_status");
    op_x(1, 0, 16'h0022, 64'h2, 64'd0, "clr0");

    // Underflow on empty ch1, then clear.
    op_x(0, 1, 16'h0028, 64'd0, 64'd0, "pop_empty");
    op_x(0, 1, 16'h002A, 64'd0, 64'h9_0000, "udf_status");
    op_x(1, 0, 16'h002A, 64'h2, 64'd0, "clr1");
    op_x(0, 1, 16'h002A, 64'd0, 64'h1_0000, "clr1_status");

    // Full channel with simultaneous push and pop.
    for (int i = 1; i <= 16; i++) op_x(1, 0, 16'h0020, 64'(i), 64'd0, "refill");
    op_x(1, 1, 16'h0020, 64'hAA, 64'h1, "push_pop_full");
    op_x(0, 1, 16'h0022, 64'd0, 64'h2_0010, "pp_status");
    for (int i = 2; i <= 16; i++) op_x(0, 1, 16'h0020, 64'd0, 64'(i), "pp_drain");
    op_x(0, 1, 16'h0020, 64'd0, 64'hAA, "pp_last");

    // Flush with 3 entries, then underflow.
    for (int i = 0; i < 3; i++) op_x(1, 0, 16'h0020, 64'(i + 9), 64'd0, "pre_flush");
    op_x(1, 0, 16'h0022, 64'h1, 64'd0, "flush");
    op_x(0, 1, 16'h0022, 64'd0, 64'h1_0000, "flush_status");
    op_x(0, 1, 16'h0020, 64'd0, 64'd0, "post_flush_pop");
    op_x(0, 1, 16'h0022, 64'd0, 64'h9_0000, "post_flush_udf");
    op_x(1, 0, 16'h0022, 64'h2, 64'd0, "clr0b");

    // Peek.
    op_x(1, 0, 16'h0020, 64'h5, 64'd0, "peek_push");
    op_x(0, 1, 16'h0024, 64'd0, PEEK_EN ? 64'h5 : 64'd0, "peek1");
    op_x(0, 1, 16'h0024, 64'd0, PEEK_EN ? 64'h5 : 64'd0, "peek2");
    op_x(0, 1, 16'h0022, 64'd0, 64'h1, "peek_status");
    op_x(0, 1, 16'h002C, 64'd0, 64'd0, "peek_empty");
    op_x(0, 1, 16'h002A, 64'd0, 64'h1_0000, "peek_empty_status");
    op_x(0, 1, 16'h0020, 64'd0, 64'h5, "peek_pop");

    // Reset mid-operation with a read in the reset cycle.
    op(1, 0, 16'h0028, 64'h1234, "pre_rst");
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_rd_valid = 1'b1;
    bus.mmio_addr     = 16'h0028;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.valid", 64'(bus.rd_rsp_valid), 64'd0);
    chk("midrst.empty", 64'(ch_empty), 64'b11);
    rst = 1'b0;
    model_reset();
    idle();
    op_x(0, 1, 16'h002A, 64'd0, 64'h1_0000, "after_rst_status");

    // Randomized traffic.
    for (int i = 0; i < 1200; i++) begin
      wp  = (i < 600) ? 65 : 35;
      rp  = (i < 600) ? 40 : 65;
      wr  = ($urandom_range(0, 99) < wp);
      rd  = ($urandom_range(0, 99) < rp);
      sel = $urandom_range(0, 19);
      wd  = {$urandom(), $urandom()};
      if (sel < 12)       a = BASE + 16'(8 * $urandom_range(0, NUM_CH - 1));
      else if (sel < 15) begin
        a = BASE + 16'(8 * $urandom_range(0, NUM_CH - 1)) + 16'd2;
        wd[0] = ($urandom_range(0, 9) == 0);
      end
      else if (sel < 17)  a = BASE + 16'(8 * $urandom_range(0, NUM_CH - 1)) + 16'd4;
      else if (sel < 19)  a = 16'(2 * $urandom_range(0, 4));
      else                a = 16'($urandom());
      op(wr, rd, a, wd, "rand");
    end
    idle();
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
